// File: rtl/sdcard_power_sequencer.sv
// SD card power sequencer: arbitrates host power requests against an inactivity
// policy and drives power_state / voltage_sel / clk_enable of the power controller.
module sdcard_power_sequencer #(
    parameter int unsigned GOOD_TIMEOUT = 1024,
    parameter int unsigned CLK_GATE_DLY = 8,
    parameter int unsigned VSW_SETTLE   = 256
) (
    input  logic        PCLK_i,
    input  logic        PRESETn_i,
    input  logic        host_req_valid_i,
    input  logic [1:0]  host_req_state_i,
    input  logic [3:0]  host_volt_i,
    output logic        host_req_ready_o,
    input  logic        auto_en_i,
    input  logic        activity_i,
    input  logic [15:0] idle_timeout_i,
    input  logic [15:0] sleep_timeout_i,
    input  logic        power_good_i,
    input  logic        power_fault_i,
    output logic [1:0]  power_state_o,
    output logic [3:0]  voltage_sel_o,
    output logic        clk_enable_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic        timeout_err_o
);

    localparam int unsigned MAX_AB  = (GOOD_TIMEOUT > CLK_GATE_DLY) ? GOOD_TIMEOUT : CLK_GATE_DLY;
    localparam int unsigned MAX_DLY = (MAX_AB > VSW_SETTLE) ? MAX_AB : VSW_SETTLE;
    localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

    localparam logic [CNT_W-1:0] GOOD_LAST   = CNT_W'(GOOD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(CLK_GATE_DLY - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(VSW_SETTLE - 1);

    localparam logic [1:0] PS_ACTIVE = 2'b00;
    localparam logic [1:0] PS_IDLE   = 2'b01;
    localparam logic [1:0] PS_SLEEP  = 2'b10;
    localparam logic [1:0] PS_DOWN   = 2'b11;

    typedef enum logic [2:0] {
        S_DOWN, S_ACTIVE, S_IDLE, S_SLEEP,
        S_WAIT_GOOD, S_VSW_GATE, S_VSW_SETTLE, S_FAULT
    } state_e;

    state_e            state_q, state_d;
    state_e            wait_tgt_q, wait_tgt_d;
    logic              wait_done_q, wait_done_d;
    logic [1:0]        ps_q, ps_d;
    logic [3:0]        volt_q, volt_d;
    logic [3:0]        volt_tgt_q, volt_tgt_d;
    logic              clk_en_q, clk_en_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
    logic [CNT_W-1:0]  seq_cnt_q, seq_cnt_d;
    logic [15:0]       inact_q, inact_d;

    logic busy;
    logic req_acc;
    logic policy_st;

    assign busy      = (state_q == S_WAIT_GOOD) || (state_q == S_VSW_GATE) || (state_q == S_VSW_SETTLE);
    assign req_acc   = host_req_valid_i && !busy;
    assign policy_st = (state_q == S_ACTIVE) || (state_q == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q     <= S_DOWN;
            wait_tgt_q  <= S_ACTIVE;
            wait_done_q <= 1'b0;
            ps_q        <= PS_DOWN;
            volt_q      <= 4'h0;
            volt_tgt_q  <= 4'h0;
            clk_en_q    <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            seq_cnt_q   <= '0;
            inact_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_tgt_q  <= wait_tgt_d;
            wait_done_q <= wait_done_d;
            ps_q        <= ps_d;
            volt_q      <= volt_d;
            volt_tgt_q  <= volt_tgt_d;
            clk_en_q    <= clk_en_d;
            done_q      <= done_d;
            terr_q      <= terr_d;
            seq_cnt_q   <= seq_cnt_d;
            inact_q     <= inact_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d     = state_q;
        wait_tgt_d  = wait_tgt_q;
        wait_done_d = wait_done_q;
        ps_d        = ps_q;
        volt_d      = volt_q;
        volt_tgt_d  = volt_tgt_q;
        clk_en_d    = clk_en_q;
        done_d      = 1'b0;
        terr_d      = terr_q;
        seq_cnt_d   = seq_cnt_q;
        inact_d     = inact_q;

        if (power_fault_i && state_q != S_DOWN) begin
            state_d  = S_FAULT;
            ps_d     = PS_DOWN;
            clk_en_d = 1'b0;
        end else begin
            unique case (state_q)
                S_FAULT: begin
                    // Only a power-down request leaves FAULT; anything else is swallowed.
                    if (req_acc && host_req_state_i == PS_DOWN) begin
                        state_d = S_DOWN;
                        terr_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                S_WAIT_GOOD: begin
                    if (power_good_i) begin
                        state_d  = wait_tgt_q;
                        clk_en_d = (wait_tgt_q == S_ACTIVE);
                        done_d   = wait_done_q;
                    end else if (seq_cnt_q == GOOD_LAST) begin
                        state_d  = S_FAULT;
                        ps_d     = PS_DOWN;
                        clk_en_d = 1'b0;
                        terr_d   = 1'b1;
                    end else begin
                        seq_cnt_d = seq_cnt_q + CNT_W'(1);
                    end
                end
                S_VSW_GATE: begin
                    if (seq_cnt_q == GATE_LAST) begin
                        volt_d    = volt_tgt_q;
                        state_d   = S_VSW_SETTLE;
                        seq_cnt_d = '0;
                    end else begin
                        seq_cnt_d = seq_cnt_q + CNT_W'(1);
                    end
                end
                S_VSW_SETTLE: begin
                    if (seq_cnt_q == SETTLE_LAST) begin
                        clk_en_d = 1'b1;
                        state_d  = S_ACTIVE;
                        done_d   = 1'b1;
                    end else begin
                        seq_cnt_d = seq_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (req_acc) begin
                        done_d = 1'b1;
                        case (host_req_state_i)
                            PS_ACTIVE: begin
                                if (state_q == S_DOWN || state_q == S_SLEEP) begin
                                    ps_d        = PS_ACTIVE;
                                    volt_d      = host_volt_i;
                                    state_d     = S_WAIT_GOOD;
                                    wait_tgt_d  = S_ACTIVE;
                                    wait_done_d = 1'b1;
                                    seq_cnt_d   = '0;
                                    done_d      = 1'b0;
                                end else if (state_q == S_IDLE) begin
                                    ps_d     = PS_ACTIVE;
                                    clk_en_d = 1'b1;
                                    state_d  = S_ACTIVE;
                                end else if (host_volt_i != volt_q) begin
                                    volt_tgt_d = host_volt_i;
                                    clk_en_d   = 1'b0;
                                    state_d    = S_VSW_GATE;
                                    seq_cnt_d  = '0;
                                    done_d     = 1'b0;
                                end
                            end
                            PS_IDLE: begin
                                if (state_q == S_ACTIVE) begin
                                    ps_d     = PS_IDLE;
                                    clk_en_d = 1'b0;
                                    state_d  = S_IDLE;
                                end else if (state_q == S_SLEEP) begin
                                    ps_d        = PS_IDLE;
                                    state_d     = S_WAIT_GOOD;
                                    wait_tgt_d  = S_IDLE;
                                    wait_done_d = 1'b1;
                                    seq_cnt_d   = '0;
                                    done_d      = 1'b0;
                                end
                            end
                            PS_SLEEP: begin
                                if (state_q == S_ACTIVE || state_q == S_IDLE) begin
                                    ps_d     = PS_SLEEP;
                                    clk_en_d = 1'b0;
                                    state_d  = S_SLEEP;
                                end
                            end
                            default: begin
                                ps_d     = PS_DOWN;
                                clk_en_d = 1'b0;
                                state_d  = S_DOWN;
                            end
                        endcase
                    end else if (auto_en_i && activity_i) begin
                        // Wake keeps the current voltage and raises no done pulse.
                        if (state_q == S_IDLE) begin
                            ps_d     = PS_ACTIVE;
                            clk_en_d = 1'b1;
                            state_d  = S_ACTIVE;
                        end else if (state_q == S_SLEEP) begin
                            ps_d        = PS_ACTIVE;
                            state_d     = S_WAIT_GOOD;
                            wait_tgt_d  = S_ACTIVE;
                            wait_done_d = 1'b0;
                            seq_cnt_d   = '0;
                        end
                    end else if (auto_en_i) begin
                        if (state_q == S_ACTIVE && idle_timeout_i != 16'd0 && inact_q == idle_timeout_i) begin
                            ps_d     = PS_IDLE;
                            clk_en_d = 1'b0;
                            state_d  = S_IDLE;
                        end else if (state_q == S_IDLE && sleep_timeout_i != 16'd0 && inact_q == sleep_timeout_i) begin
                            ps_d     = PS_SLEEP;
                            clk_en_d = 1'b0;
                            state_d  = S_SLEEP;
                        end
                    end
                end
            endcase
        end

        // Counter holds completed inactive cycles; the move fires in the cycle it equals the timeout.
        if (!auto_en_i || activity_i || !policy_st || state_d != state_q) begin
            inact_d = '0;
        end else if (inact_q != 16'hFFFF) begin
            inact_d = inact_q + 16'd1;
        end
    end

    assign host_req_ready_o = !busy;
    assign busy_o           = busy;
    assign power_state_o    = ps_q;
    assign voltage_sel_o    = volt_q;
    assign clk_enable_o     = clk_en_q;
    assign done_o           = done_q;
    assign fault_o          = (state_q == S_FAULT);
    assign timeout_err_o    = terr_q;

endmodule

// File: tb/tb_sdcard_power_sequencer.sv
// Bench for sdcard_power_sequencer: a deadline/timestamp model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sdcard_power_sequencer;

    localparam int GOOD_TIMEOUT = 1024;
    localparam int CLK_GATE_DLY = 8;
    localparam int VSW_SETTLE   = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_state = 2'b00;
    logic [3:0]  req_volt = 4'h0;
    logic        auto_en = 1'b0;
    logic        activity = 1'b0;
    logic [15:0] idle_to = 16'd0;
    logic [15:0] sleep_to = 16'd0;
    logic        power_good = 1'b0;
    logic        power_fault = 1'b0;

    logic        ready_o, clk_en_o, busy_o, done_o, fault_o, terr_o;
    logic [1:0]  ps_o;
    logic [3:0]  volt_o;

    sdcard_power_sequencer #(
        .GOOD_TIMEOUT(GOOD_TIMEOUT),
        .CLK_GATE_DLY(CLK_GATE_DLY),
        .VSW_SETTLE  (VSW_SETTLE)
    ) dut (
        .PCLK_i          (clk),
        .PRESETn_i       (rst_n),
        .host_req_valid_i(req_valid),
        .host_req_state_i(req_state),
        .host_volt_i     (req_volt),
        .host_req_ready_o(ready_o),
        .auto_en_i       (auto_en),
        .activity_i      (activity),
        .idle_timeout_i  (idle_to),
        .sleep_timeout_i (sleep_to),
        .power_good_i    (power_good),
        .power_fault_i   (power_fault),
        .power_state_o   (ps_o),
        .voltage_sel_o   (volt_o),
        .clk_enable_o    (clk_en_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .fault_o         (fault_o),
        .timeout_err_o   (terr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    // Model: power code plus a phase; delays tracked as absolute deadline cycles,
    // inactivity as the cycle at which the current quiet stretch began.
    typedef enum int {PH_STABLE, PH_WAIT, PH_GATE, PH_SETTLE, PH_FAULT} phase_e;

    phase_e     m_phase, p_phase;
    logic [1:0] m_ps, p_ps;
    logic [3:0] m_volt, m_tgt;
    logic       m_clk, m_done, m_terr, m_wait_done, accept;
    int         m_cyc, m_quiet_from, m_deadline, quiet;

    task automatic enter_wait(input logic [1:0] code, input logic with_done);
        m_ps        = code;
        m_phase     = PH_WAIT;
        m_deadline  = m_cyc + GOOD_TIMEOUT;
        m_wait_done = with_done;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = PH_STABLE; m_ps = 2'b11; m_volt = 4'h0; m_tgt = 4'h0;
            m_clk = 1'b0; m_done = 1'b0; m_terr = 1'b0; m_wait_done = 1'b0;
            m_cyc = 0; m_quiet_from = 1; m_deadline = 0;
        end else begin
            m_cyc++;
            m_done  = 1'b0;
            p_phase = m_phase;
            p_ps    = m_ps;
            quiet   = m_cyc - m_quiet_from;
            if (quiet > 65535) quiet = 65535;
            accept = req_valid && (m_phase == PH_STABLE || m_phase == PH_FAULT);
            if (power_fault && !(m_phase == PH_STABLE && m_ps == 2'b11)) begin
                m_phase = PH_FAULT; m_ps = 2'b11; m_clk = 1'b0;
            end else if (m_phase == PH_FAULT) begin
                if (accept && req_state == 2'b11) begin
                    m_phase = PH_STABLE; m_terr = 1'b0; m_done = 1'b1;
                end
            end else if (m_phase == PH_WAIT) begin
                if (power_good) begin
                    m_phase = PH_STABLE; m_clk = (m_ps == 2'b00); m_done = m_wait_done;
                end else if (m_cyc == m_deadline) begin
                    m_phase = PH_FAULT; m_ps = 2'b11; m_clk = 1'b0; m_terr = 1'b1;
                end
            end else if (m_phase == PH_GATE) begin
                if (m_cyc == m_deadline) begin
                    m_volt = m_tgt; m_phase = PH_SETTLE; m_deadline = m_cyc + VSW_SETTLE;
                end
            end else if (m_phase == PH_SETTLE) begin
                if (m_cyc == m_deadline) begin
                    m_clk = 1'b1; m_phase = PH_STABLE; m_done = 1'b1;
                end
            end else if (accept) begin
                m_done = 1'b1;
                case (req_state)
                    2'b00: begin
                        if (m_ps == 2'b11 || m_ps == 2'b10) begin
                            m_volt = req_volt; enter_wait(2'b00, 1'b1); m_done = 1'b0;
                        end else if (m_ps == 2'b01) begin
                            m_ps = 2'b00; m_clk = 1'b1;
                        end else if (req_volt != m_volt) begin
                            m_tgt = req_volt; m_clk = 1'b0; m_phase = PH_GATE;
                            m_deadline = m_cyc + CLK_GATE_DLY; m_done = 1'b0;
                        end
                    end
                    2'b01: begin
                        if (m_ps == 2'b00) begin
                            m_ps = 2'b01; m_clk = 1'b0;
                        end else if (m_ps == 2'b10) begin
                            enter_wait(2'b01, 1'b1); m_done = 1'b0;
                        end
                    end
                    2'b10: if (m_ps == 2'b00 || m_ps == 2'b01) begin m_ps = 2'b10; m_clk = 1'b0; end
                    default: begin m_ps = 2'b11; m_clk = 1'b0; end
                endcase
            end else if (auto_en && activity && m_ps == 2'b01) begin
                m_ps = 2'b00; m_clk = 1'b1;
            end else if (auto_en && activity && m_ps == 2'b10) begin
                enter_wait(2'b00, 1'b0);
            end else if (auto_en && !activity && m_ps == 2'b00 && idle_to != 0 && quiet == int'(idle_to)) begin
                m_ps = 2'b01; m_clk = 1'b0;
            end else if (auto_en && !activity && m_ps == 2'b01 && sleep_to != 0 && quiet == int'(sleep_to)) begin
                m_ps = 2'b10; m_clk = 1'b0;
            end
            if (!auto_en || activity || m_phase != p_phase || m_ps != p_ps ||
                p_phase != PH_STABLE || !(p_ps == 2'b00 || p_ps == 2'b01))
                m_quiet_from = m_cyc + 1;
        end
    end

    logic [11:0] exp_v, act_v;
    logic        m_busy;

    always @(negedge clk) begin
        m_busy = (m_phase == PH_WAIT) || (m_phase == PH_GATE) || (m_phase == PH_SETTLE);
        exp_v  = {m_ps, m_volt, m_clk, !m_busy, m_busy, m_done, m_phase == PH_FAULT, m_terr};
        act_v  = {ps_o, volt_o, clk_en_o, ready_o, busy_o, done_o, fault_o, terr_o};
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL cycle_model t=%0t got ps/volt/clk/rdy/busy/done/flt/terr=%b want %b",
                      $time, act_v, exp_v);
        if (done_o === 1'b1) n_done++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h want %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic request(input logic [1:0] st, input logic [3:0] v);
        req_valid = 1'b1; req_state = st; req_volt = v;
        tick(1);
        req_valid = 1'b0;
    endtask

    int d0;

    initial begin
        tick(3);
        check("rst_ps", ps_o, 3);       check("rst_volt", volt_o, 0);
        check("rst_clk", clk_en_o, 0);  check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);   check("rst_done", done_o, 0);
        check("rst_fault", fault_o, 0); check("rst_terr", terr_o, 0);
        rst_n = 1'b1;
        tick(1);

        // Power-up to ACTIVE at volt 3, power_good rises 5 cycles after accept.
        d0 = n_done;
        request(2'b00, 4'h3);
        check("up_ps", ps_o, 0); check("up_busy", busy_o, 1); check("up_ready", ready_o, 0);
        tick(4);
        check("up_clk_wait", clk_en_o, 0);
        power_good = 1'b1;
        tick(1);
        check("up_clk", clk_en_o, 1); check("up_volt", volt_o, 3); check("up_done", done_o, 1);
        tick(1);
        check("up_done_count", n_done - d0, 1);

        // Voltage switch 3 -> 1.
        request(2'b00, 4'h1);
        check("vsw_clk_off", clk_en_o, 0); check("vsw_ready", ready_o, 0);
        tick(7);
        check("vsw_volt_hold", volt_o, 3);
        tick(1);
        check("vsw_volt_new", volt_o, 1); check("vsw_clk_still_off", clk_en_o, 0);
        tick(255);
        check("vsw_settle_clk", clk_en_o, 0); check("vsw_settle_ready", ready_o, 0);
        tick(1);
        check("vsw_clk_on", clk_en_o, 1); check("vsw_done", done_o, 1); check("vsw_ready_back", ready_o, 1);

        // Same voltage: immediate done, nothing changes.
        request(2'b00, 4'h1);
        check("same_done", done_o, 1); check("same_busy", busy_o, 0);

        // Inactivity policy: ACTIVE -> IDLE -> SLEEP, then wake.
        idle_to = 16'd10; sleep_to = 16'd20; auto_en = 1'b1;
        tick(10);
        check("auto_still_active", ps_o, 0);
        tick(1);
        check("auto_idle", ps_o, 1); check("auto_idle_clk", clk_en_o, 0); check("auto_idle_nodone", done_o, 0);
        tick(20);
        check("auto_still_idle", ps_o, 1);
        tick(1);
        check("auto_sleep", ps_o, 2);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        check("wake_ps", ps_o, 0); check("wake_busy", busy_o, 1); check("wake_volt", volt_o, 1);
        tick(1);
        check("wake_clk", clk_en_o, 1); check("wake_nodone", done_o, 0);

        // Activity in the cycle the idle timeout would fire.
        tick(10);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        check("act_beats_timeout", ps_o, 0);
        tick(10);
        check("counter_restarted", ps_o, 0);
        tick(1);
        check("idle_after_restart", ps_o, 1);
        auto_en = 1'b0;

        // Host sleep, then IDLE from SLEEP via power_good, then ACTIVE.
        request(2'b10, 4'h0);
        check("req_sleep", ps_o, 2); check("req_sleep_done", done_o, 1);
        request(2'b01, 4'h0);
        check("sleep_to_idle_wait", busy_o, 1); check("sleep_to_idle_ps", ps_o, 1);
        tick(1);
        check("sleep_to_idle_done", done_o, 1); check("sleep_to_idle_clk", clk_en_o, 0);
        request(2'b00, 4'h1);
        check("idle_to_active", ps_o, 0); check("idle_to_active_clk", clk_en_o, 1);

        // Fault during VSW_SETTLE together with a host request.
        request(2'b00, 4'h5);
        tick(8);
        check("flt_in_settle", volt_o, 5);
        tick(10);
        power_fault = 1'b1; req_valid = 1'b1; req_state = 2'b11;
        tick(1);
        power_fault = 1'b0; req_valid = 1'b0;
        check("flt_fault", fault_o, 1); check("flt_ps", ps_o, 3);
        check("flt_clk", clk_en_o, 0); check("flt_nodone", done_o, 0);
        request(2'b01, 4'h0);
        check("flt_ignore", fault_o, 1); check("flt_ignore_nodone", done_o, 0);
        request(2'b11, 4'h0);
        check("flt_clear", fault_o, 0); check("flt_clear_done", done_o, 1);

        // Requests 01/10 from DOWN are ignored but acknowledged; fault ignored in DOWN.
        request(2'b01, 4'h0);
        check("down_idle_done", done_o, 1); check("down_idle_ps", ps_o, 3);
        request(2'b10, 4'h0);
        check("down_sleep_ps", ps_o, 3);
        power_fault = 1'b1;
        tick(1);
        power_fault = 1'b0;
        check("down_fault_ignored", fault_o, 0);

        // power_good timeout.
        power_good = 1'b0;
        request(2'b00, 4'h2);
        tick(1023);
        check("to_before", fault_o, 0); check("to_busy", busy_o, 1);
        tick(1);
        check("to_fault", fault_o, 1); check("to_terr", terr_o, 1); check("to_ps", ps_o, 3);
        request(2'b11, 4'h0);
        check("to_clear_fault", fault_o, 0); check("to_clear_terr", terr_o, 0); check("to_done", done_o, 1);

        // Reset in the middle of a voltage switch.
        power_good = 1'b1;
        request(2'b00, 4'h4);
        tick(1);
        check("pre_rst_volt", volt_o, 4);
        request(2'b00, 4'h9);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_volt", volt_o, 0); check("mid_rst_ps", ps_o, 3); check("mid_rst_ready", ready_o, 1);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_ps", ps_o, 3); check("post_rst_volt", volt_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
